// File: rtl/mv_mem_arbiter.sv
// Arbitrates one single-port motion-vector RAM between the ME writer (A) and the median filter (B).
// Round-robin grants with an optional ownership lock; read data is routed back to its owner after RD_LAT cycles.
module mv_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 9,
    parameter int RD_LAT = 1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    input  logic              b_req,
    input  logic              b_we,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Handshake: a requester holds req (with we/addr/wdata/lock valid) until it sees gnt in the
    // same cycle; the RAM access happens in that gnt cycle and req may change on the next cycle.
    typedef enum logic [1:0] {
        ARB    = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    state_t            state;
    logic              rr_last;   // 1: B held the most recent grant
    logic [RD_LAT-1:0] tag_v;
    logic [RD_LAT-1:0] tag_b;     // owner of each in-flight read, 1 = B
    logic              tail_v;

    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!reset) begin
            case (state)
                LOCK_A: a_gnt = a_req;
                LOCK_B: b_gnt = b_req;
                default: begin
                    if (a_req && b_req) begin
                        a_gnt = rr_last;
                        b_gnt = !rr_last;
                    end else begin
                        a_gnt = a_req;
                        b_gnt = b_req;
                    end
                end
            endcase
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (a_gnt) begin
            mem_we    = a_we;
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
        end else if (b_gnt) begin
            mem_we    = b_we;
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
        end
    end

    assign mem_en = a_gnt | b_gnt;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state   <= ARB;
            rr_last <= 1'b1;
        end else begin
            if (a_gnt) begin
                rr_last <= 1'b0;
            end else if (b_gnt) begin
                rr_last <= 1'b1;
            end
            case (state)
                ARB: begin
                    // A lock only takes hold when it accompanies a grant.
                    if (a_gnt && a_lock) begin
                        state <= LOCK_A;
                    end else if (b_gnt && b_lock) begin
                        state <= LOCK_B;
                    end
                end
                LOCK_A:  if (!a_lock) state <= ARB;
                LOCK_B:  if (!b_lock) state <= ARB;
                default: state <= ARB;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            tag_v <= '0;
            tag_b <= '0;
        end else begin
            tag_v[0] <= mem_en & !mem_we;
            tag_b[0] <= b_gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_b[i] <= tag_b[i-1];
            end
        end
    end

    // The tail tag lines up with the RAM output; data passes straight through to the owner.
    assign tail_v    = tag_v[RD_LAT-1] & !reset;
    assign a_rvalid  = tail_v & !tag_b[RD_LAT-1];
    assign b_rvalid  = tail_v & tag_b[RD_LAT-1];
    assign rdata     = tail_v ? mem_rdata : '0;
    assign busy      = (|tag_v) | (state != ARB);
    assign dbg_state = state;

endmodule

// File: tb/tb_mv_mem_arbiter.sv
// Bench for mv_mem_arbiter: two instances (RD_LAT 1 and 3) share stimulus, each with its own RAM,
// checked every cycle against a queue-based model plus directed literal checks.
module tb_mv_mem_arbiter;

    logic CLK = 1'b0;
    logic reset;
    logic a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [15:0] a_addr, b_addr;
    logic [8:0] a_wdata, b_wdata;

    logic a_gnt_1, a_rvalid_1, b_gnt_1, b_rvalid_1, mem_en_1, mem_we_1, busy_1;
    logic [8:0] rdata_1, mem_wdata_1, mem_rdata_1;
    logic [15:0] mem_addr_1;
    logic [1:0] dbg_1;
    logic a_gnt_3, a_rvalid_3, b_gnt_3, b_rvalid_3, mem_en_3, mem_we_3, busy_3;
    logic [8:0] rdata_3, mem_wdata_3, mem_rdata_3;
    logic [15:0] mem_addr_3;
    logic [1:0] dbg_3;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit started = 0;

    always #5 CLK = ~CLK;

    mv_mem_arbiter #(.ADDR_W(16), .DATA_W(9), .RD_LAT(1)) u_dut1 (
        .CLK(CLK), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt_1), .a_rvalid(a_rvalid_1),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt_1), .b_rvalid(b_rvalid_1),
        .rdata(rdata_1), .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1),
        .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata_1), .busy(busy_1), .dbg_state(dbg_1)
    );

    mv_mem_arbiter #(.ADDR_W(16), .DATA_W(9), .RD_LAT(3)) u_dut3 (
        .CLK(CLK), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt_3), .a_rvalid(a_rvalid_3),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt_3), .b_rvalid(b_rvalid_3),
        .rdata(rdata_3), .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3),
        .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata_3), .busy(busy_3), .dbg_state(dbg_3)
    );

    // RAM models: 64 words, addresses kept below 64
    logic [8:0] ram1 [64];
    logic [8:0] ram3 [64];
    logic [8:0] rp1;
    logic [8:0] rp3 [3];

    always @(posedge CLK) begin
        if (mem_en_1 && mem_we_1) ram1[mem_addr_1[5:0]] <= mem_wdata_1;
        rp1 <= (mem_en_1 && !mem_we_1) ? ram1[mem_addr_1[5:0]] : 9'h1FF;
        if (mem_en_3 && mem_we_3) ram3[mem_addr_3[5:0]] <= mem_wdata_3;
        rp3[0] <= (mem_en_3 && !mem_we_3) ? ram3[mem_addr_3[5:0]] : 9'h1FF;
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign mem_rdata_1 = rp1;
    assign mem_rdata_3 = rp3[2];

    // Model: lock holder (0 none, 1 A, 2 B), last winner (1 = B), shadow memory, pending reads.
    int m_lock = 0;
    logic m_last = 1'b1;
    logic [8:0] sh [64];
    // entry = {due cycle[41:10], owner_is_b[9], data[8:0]}
    logic [41:0] exp_q1[$];
    logic [41:0] exp_q3[$];

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram1[i] = 9'((i * 7 + 64) % 512);
            ram3[i] = 9'((i * 7 + 64) % 512);
            sh[i]   = 9'((i * 7 + 64) % 512);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_cycle();
        logic ea, eb, ewe;
        logic [15:0] eaddr;
        logic [8:0] ewd;
        logic [41:0] f;
        logic av1, bv1, av3, bv3, bs1, bs3;
        logic [8:0] rd1, rd3;
        ea = 0; eb = 0; ewe = 0; eaddr = '0; ewd = '0;
        av1 = 0; bv1 = 0; av3 = 0; bv3 = 0; rd1 = '0; rd3 = '0; bs1 = 0; bs3 = 0;
        if (!reset) begin
            if (m_lock == 1) ea = a_req;
            else if (m_lock == 2) eb = b_req;
            else if (a_req && b_req) begin
                ea = m_last;
                eb = !m_last;
            end else begin
                ea = a_req;
                eb = b_req;
            end
            if (ea) begin ewe = a_we; eaddr = a_addr; ewd = a_wdata; end
            else if (eb) begin ewe = b_we; eaddr = b_addr; ewd = b_wdata; end
            bs1 = (exp_q1.size() > 0) || (m_lock != 0);
            bs3 = (exp_q3.size() > 0) || (m_lock != 0);
            if (exp_q1.size() > 0 && exp_q1[0][41:10] == 32'(cyc)) begin
                f = exp_q1.pop_front();
                av1 = !f[9]; bv1 = f[9]; rd1 = f[8:0];
            end
            if (exp_q3.size() > 0 && exp_q3[0][41:10] == 32'(cyc)) begin
                f = exp_q3.pop_front();
                av3 = !f[9]; bv3 = f[9]; rd3 = f[8:0];
            end
        end
        chk("a_gnt_1", a_gnt_1, ea);         chk("b_gnt_1", b_gnt_1, eb);
        chk("a_gnt_3", a_gnt_3, ea);         chk("b_gnt_3", b_gnt_3, eb);
        chk("mem_en_1", mem_en_1, ea | eb);  chk("mem_we_1", mem_we_1, ewe);
        chk("mem_addr_1", mem_addr_1, eaddr); chk("mem_wdata_1", mem_wdata_1, ewd);
        chk("mem_addr_3", mem_addr_3, eaddr); chk("mem_we_3", mem_we_3, ewe);
        chk("a_rvalid_1", a_rvalid_1, av1);  chk("b_rvalid_1", b_rvalid_1, bv1);
        chk("rdata_1", rdata_1, rd1);
        chk("a_rvalid_3", a_rvalid_3, av3);  chk("b_rvalid_3", b_rvalid_3, bv3);
        chk("rdata_3", rdata_3, rd3);
        if (!reset) begin
            chk("busy_1", busy_1, bs1);
            chk("busy_3", busy_3, bs3);
        end
        if (reset) begin
            m_lock = 0;
            m_last = 1'b1;
            exp_q1.delete();
            exp_q3.delete();
        end else begin
            if (ea || eb) begin
                m_last = eb;
                if (ewe) sh[eaddr[5:0]] = ewd;
                else begin
                    exp_q1.push_back({32'(cyc + 1), eb, sh[eaddr[5:0]]});
                    exp_q3.push_back({32'(cyc + 3), eb, sh[eaddr[5:0]]});
                end
            end
            if (m_lock == 0) begin
                if (ea && a_lock) m_lock = 1;
                else if (eb && b_lock) m_lock = 2;
            end else if (m_lock == 1 && !a_lock) m_lock = 0;
            else if (m_lock == 2 && !b_lock) m_lock = 0;
        end
        cyc++;
    endtask

    always @(negedge CLK) if (started) model_cycle();

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    task automatic drain(input int n);
        a_req = 0; b_req = 0; a_lock = 0; b_lock = 0;
        repeat (n) nxt();
    endtask

    task automatic random_phase(input int n);
        logic ag, bg;
        for (int i = 0; i < n; i++) begin
            smp();
            ag = a_gnt_1;
            bg = b_gnt_1;
            nxt();
            if (!a_req || ag) begin
                a_req   = ($urandom_range(0, 99) < 60);
                a_we    = 1'($urandom_range(0, 1));
                a_addr  = 16'($urandom_range(0, 63));
                a_wdata = 9'($urandom_range(0, 511));
            end
            if (!b_req || bg) begin
                b_req   = ($urandom_range(0, 99) < 60);
                b_we    = ($urandom_range(0, 3) == 0);
                b_addr  = 16'($urandom_range(0, 63));
                b_wdata = 9'($urandom_range(0, 511));
            end
            if ($urandom_range(0, 5) == 0) a_lock = !a_lock;
            if ($urandom_range(0, 5) == 0) b_lock = !b_lock;
            reset = ($urandom_range(0, 399) == 0);
        end
        reset = 0;
    endtask

    initial begin
        reset = 1;
        a_req = 0; a_we = 0; a_lock = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_lock = 0; b_addr = '0; b_wdata = '0;
        repeat (3) nxt();

        // reset state, then simultaneous reads of 5 and 6: A wins the first tie
        reset = 0; started = 1;
        a_req = 1; a_addr = 16'd5; b_req = 1; b_addr = 16'd6;
        smp();
        chk("t1_state", dbg_1, 2'd0);
        chk("t1_a_gnt", a_gnt_1, 1'b1);
        chk("t1_b_wait", b_gnt_1, 1'b0);
        nxt(); a_req = 0;
        smp();
        chk("t1_a_rvalid", a_rvalid_1, 1'b1);
        chk("t1_rdata_a", rdata_1, 9'h063);
        chk("t1_b_gnt", b_gnt_1, 1'b1);
        nxt(); b_req = 0;
        smp();
        chk("t1_b_rvalid", b_rvalid_1, 1'b1);
        chk("t1_rdata_b", rdata_1, 9'h06A);
        nxt(); drain(4);

        // continuous requests alternate A,B,...
        a_req = 1; b_req = 1; a_addr = 16'd10; b_addr = 16'd20;
        for (int i = 0; i < 8; i++) begin
            smp();
            chk("t2_a_gnt", a_gnt_1, (i % 2) == 0);
            chk("t2_addr", mem_addr_1, (i % 2) == 0 ? 32'd10 : 32'd20);
            nxt();
        end
        drain(4);

        // one A write so B wins the next tie, then B locks for 9 reads
        a_req = 1; a_we = 1; a_addr = 16'd40; a_wdata = 9'h011;
        smp(); nxt();
        a_req = 1; a_we = 0; a_addr = 16'd7; b_req = 1; b_we = 0;
        for (int i = 0; i < 9; i++) begin
            b_addr = 16'(30 + i);
            b_lock = (i < 8);
            smp();
            chk("t3_b_gnt", b_gnt_1, 1'b1);
            chk("t3_a_blocked", a_gnt_1, 1'b0);
            nxt();
        end
        b_req = 0; b_lock = 0;
        smp();
        chk("t3_a_after", a_gnt_1, 1'b1);
        nxt(); drain(4);

        // write then read-back of the same word
        a_req = 1; a_we = 1; a_addr = 16'd3; a_wdata = 9'h0A5;
        smp(); chk("t4_a_wr_gnt", a_gnt_1, 1'b1); nxt();
        a_req = 0; a_we = 0; b_req = 1; b_we = 0; b_addr = 16'd3;
        smp(); chk("t4_b_gnt", b_gnt_1, 1'b1); nxt();
        b_req = 0;
        smp();
        chk("t4_b_rvalid", b_rvalid_1, 1'b1);
        chk("t4_rdata", rdata_1, 9'h0A5);
        chk("t4_no_a_rvalid", a_rvalid_1, 1'b0);
        nxt(); drain(4);

        // three back-to-back reads, reset in the third cycle discards them
        b_req = 1; b_addr = 16'd11; smp(); nxt();
        b_addr = 16'd12; smp(); nxt();
        b_addr = 16'd13; reset = 1; smp(); nxt();
        reset = 0; b_req = 0;
        smp();
        chk("t5_busy", busy_3, 1'b0);
        chk("t5_mem_en", mem_en_3, 1'b0);
        chk("t5_state", dbg_3, 2'd0);
        for (int i = 0; i < 4; i++) begin
            chk("t5_no_rvalid", b_rvalid_3, 1'b0);
            nxt(); smp();
        end
        nxt(); drain(2);

        // lone B read right after an A grant, busy only over the tag lifetime
        a_req = 1; a_we = 1; a_addr = 16'd1; a_wdata = 9'h100;
        smp(); chk("t6_a_gnt", a_gnt_1, 1'b1); chk("t6_busy0", busy_1, 1'b0); nxt();
        a_req = 0; a_we = 0; b_req = 1; b_we = 0; b_lock = 0; b_addr = 16'd2;
        smp(); chk("t6_b_gnt", b_gnt_1, 1'b1); chk("t6_busy1", busy_1, 1'b0); nxt();
        b_req = 0;
        smp(); chk("t6_busy2", busy_1, 1'b1); chk("t6_b_rvalid", b_rvalid_1, 1'b1); nxt();
        smp(); chk("t6_busy3", busy_1, 1'b0); nxt();

        random_phase(3000);
        drain(6);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
